// File: rtl/sam_pkg.sv
// Shared definitions for the SAM sequencer: state encodings, opcodes,
// control-word bit positions and a one-hot helper for building b.
package sam_pkg;

  localparam int CTRL_W = 22;

  localparam logic [4:0] ENC_INIT   = 5'd0;
  localparam logic [4:0] ENC_IDLE   = 5'd1;
  localparam logic [4:0] ENC_F_MAR  = 5'd2;
  localparam logic [4:0] ENC_F_REQ  = 5'd3;
  localparam logic [4:0] ENC_F_LAT  = 5'd4;
  localparam logic [4:0] ENC_F_IR   = 5'd5;
  localparam logic [4:0] ENC_DEC    = 5'd6;
  localparam logic [4:0] ENC_R_REQ  = 5'd7;
  localparam logic [4:0] ENC_R_LAT  = 5'd8;
  localparam logic [4:0] ENC_LD0    = 5'd9;
  localparam logic [4:0] ENC_LD1    = 5'd10;
  localparam logic [4:0] ENC_AD0    = 5'd11;
  localparam logic [4:0] ENC_AD1    = 5'd12;
  localparam logic [4:0] ENC_ST0    = 5'd13;
  localparam logic [4:0] ENC_ST_REQ = 5'd14;
  localparam logic [4:0] ENC_BR     = 5'd15;
  localparam logic [4:0] ENC_FAULT  = 5'd16;

  typedef enum logic [4:0] {
    INIT = ENC_INIT, IDLE = ENC_IDLE, F_MAR = ENC_F_MAR, F_REQ = ENC_F_REQ,
    F_LAT = ENC_F_LAT, F_IR = ENC_F_IR, DEC = ENC_DEC, R_REQ = ENC_R_REQ,
    R_LAT = ENC_R_LAT, LD0 = ENC_LD0, LD1 = ENC_LD1, AD0 = ENC_AD0,
    AD1 = ENC_AD1, ST0 = ENC_ST0, ST_REQ = ENC_ST_REQ, BR = ENC_BR,
    FAULT = ENC_FAULT
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_BRN   = 2'b11;

  localparam int B_PC_ABUS   = 21;
  localparam int B_IR_ABUS   = 20;
  localparam int B_MBR_ABUS  = 19;
  localparam int B_RBUS_AC   = 18;
  localparam int B_AC_ALUA   = 17;
  localparam int B_MBUS_ALUB = 16;
  localparam int B_ALU_ADD   = 15;
  localparam int B_ALU_PASSB = 14;
  localparam int B_MAR_ADDR  = 13;
  localparam int B_MBR_DATA  = 12;
  localparam int B_ABUS_IR   = 11;
  localparam int B_ABUS_MAR  = 10;
  localparam int B_DATA_MBR  = 9;
  localparam int B_RBUS_MBR  = 8;
  localparam int B_MBR_MBUS  = 7;
  localparam int B_PC_CLR    = 6;
  localparam int B_PC_INC    = 5;
  localparam int B_ABUS_PC   = 4;
  localparam int B_RW        = 3;
  localparam int B_REQ       = 2;
  localparam int B_AC_RBUS   = 1;
  localparam int B_ALU_RBUS  = 0;

  function automatic logic [CTRL_W-1:0] bm(input int idx);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/sam_sequencer_if.sv
// Sequencer <-> datapath/memory-handshake signal bundle. master = sequencer.
interface sam_sequencer_if;
  import sam_pkg::*;

  logic              run;
  logic              wait_i;
  logic [1:0]        ir_op;
  logic              ac_sign;
  logic [CTRL_W-1:0] b;
  logic [4:0]        state_o;
  logic              instr_done;
  logic              fault;

  modport master (
    input  run, wait_i, ir_op, ac_sign,
    output b, state_o, instr_done, fault
  );

  modport slave (
    output run, wait_i, ir_op, ac_sign,
    input  b, state_o, instr_done, fault
  );
endinterface

// File: rtl/sam_req_timer.sv
// Request hold counter for *_REQ states; with SAM_SEQ_TIMEOUT_EN also
// counts consecutive wait_i cycles and flags a memory timeout.
module sam_req_timer #(
  parameter int REQ_SETUP = 1
`ifdef SAM_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_req,
  input  logic wait_i,
  output logic req_ok,
  output logic timeout
);

  localparam int SW = $clog2(REQ_SETUP + 2);

  // Cleared whenever no request is active, so every *_REQ entry starts at 0.
  logic [SW-1:0] setup_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              setup_cnt <= '0;
    else if (!in_req)                        setup_cnt <= '0;
    else if (setup_cnt != SW'(REQ_SETUP))    setup_cnt <= setup_cnt + 1'b1;
  end

  assign req_ok = in_req && !wait_i && (setup_cnt == SW'(REQ_SETUP));

`ifdef SAM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (in_req && wait_i) begin
      if (wait_cnt != TW'(TIMEOUT_CYC)) wait_cnt <= wait_cnt + 1'b1;
    end
    else                        wait_cnt <= '0;
  end

  // Fires during the TIMEOUT_CYC-th consecutive busy cycle.
  assign timeout = in_req && wait_i && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/sam_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the SAM accumulator datapath.
// Optional memory timeout fault enabled by defining SAM_SEQ_TIMEOUT_EN.
module sam_sequencer
  import sam_pkg::*;
#(
  parameter int CTRL_W_P  = CTRL_W,
  parameter int REQ_SETUP = 1
`ifdef SAM_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  sam_sequencer_if.master bus
);

  state_t state, state_nx;
  logic   in_req, req_ok, timeout;
  logic [CTRL_W_P-1:0] b_d;
  logic   done_d;

  assign in_req = (state == F_REQ) || (state == R_REQ) || (state == ST_REQ);

  sam_req_timer #(
    .REQ_SETUP  (REQ_SETUP)
`ifdef SAM_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_req  (in_req),
    .wait_i  (bus.wait_i),
    .req_ok  (req_ok),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT, IDLE: state_nx = bus.run ? F_MAR : IDLE;
      F_MAR:  state_nx = F_REQ;
      F_REQ:  state_nx = timeout ? FAULT : (req_ok ? F_LAT : F_REQ);
      F_LAT:  state_nx = F_IR;
      F_IR:   state_nx = DEC;
      DEC: begin
        unique case (bus.ir_op)
          OP_STORE: state_nx = ST0;
          OP_BRN:   state_nx = BR;
          default:  state_nx = R_REQ;
        endcase
      end
      R_REQ:  state_nx = timeout ? FAULT : (req_ok ? R_LAT : R_REQ);
      R_LAT:  state_nx = (bus.ir_op == OP_ADD) ? AD0 : LD0;
      LD0:    state_nx = LD1;
      AD0:    state_nx = AD1;
      ST0:    state_nx = ST_REQ;
      ST_REQ: begin
        if (timeout)     state_nx = FAULT;
        else if (req_ok) state_nx = bus.run ? F_MAR : IDLE;
      end
      LD1, AD1, BR: state_nx = bus.run ? F_MAR : IDLE;
      FAULT:  state_nx = FAULT;
      default: state_nx = INIT;
    endcase
  end

  // STORE completes when the write handshake is accepted, so its done pulse
  // follows req_ok rather than the state alone.
  always_comb begin
    b_d    = '0;
    done_d = 1'b0;
    unique case (state)
      INIT:   b_d = bm(B_PC_CLR);
      F_MAR:  b_d = bm(B_PC_ABUS) | bm(B_ABUS_MAR);
      F_REQ,
      R_REQ:  b_d = bm(B_MAR_ADDR) | bm(B_REQ);
      F_LAT,
      R_LAT:  b_d = bm(B_MAR_ADDR) | bm(B_DATA_MBR);
      F_IR:   b_d = bm(B_MBR_ABUS) | bm(B_ABUS_IR) | bm(B_PC_INC);
      DEC:    b_d = bm(B_IR_ABUS) | bm(B_ABUS_MAR);
      LD0:    b_d = bm(B_MBR_MBUS) | bm(B_MBUS_ALUB) | bm(B_ALU_PASSB);
      LD1: begin
        b_d    = bm(B_ALU_PASSB) | bm(B_ALU_RBUS) | bm(B_RBUS_AC);
        done_d = 1'b1;
      end
      AD0:    b_d = bm(B_AC_ALUA) | bm(B_MBR_MBUS) | bm(B_MBUS_ALUB);
      AD1: begin
        b_d    = bm(B_ALU_ADD) | bm(B_ALU_RBUS) | bm(B_RBUS_AC);
        done_d = 1'b1;
      end
      ST0:    b_d = bm(B_AC_RBUS) | bm(B_RBUS_MBR);
      ST_REQ: begin
        b_d    = bm(B_MAR_ADDR) | bm(B_MBR_DATA) | bm(B_RW) | bm(B_REQ);
        done_d = req_ok;
      end
      BR: begin
        b_d    = bus.ac_sign ? (bm(B_IR_ABUS) | bm(B_ABUS_PC)) : '0;
        done_d = 1'b1;
      end
      default: b_d = '0;
    endcase
  end

  assign bus.b          = b_d;
  assign bus.state_o    = state;
  assign bus.instr_done = done_d;
`ifdef SAM_SEQ_TIMEOUT_EN
  assign bus.fault      = (state == FAULT);
`else
  assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_sam_sequencer.sv
// Directed bench for sam_sequencer: LOAD/ADD/STORE/BRN sequences, wait
// stretching, run drop, async reset and (with SAM_SEQ_TIMEOUT_EN) timeout.
module tb_sam_sequencer;
  import sam_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  sam_sequencer_if bus ();

  sam_sequencer #(
    .REQ_SETUP (1)
`ifdef SAM_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(bus.state_o), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From any state that is followed by F_MAR, walk the fetch up to DEC.
  task automatic to_dec();
    tick(); chk_st("f_mar", F_MAR); chk("b_f_mar", 32'(bus.b), 32'h200400);
    tick(); chk_st("f_req1", F_REQ); chk("b_f_req", 32'(bus.b), 32'h002004);
    tick(); chk_st("f_req2", F_REQ);
    tick(); chk_st("f_lat", F_LAT); chk("b_f_lat", 32'(bus.b), 32'h002200);
    tick(); chk_st("f_ir", F_IR);   chk("b_f_ir", 32'(bus.b), 32'h080820);
    tick(); chk_st("dec", DEC);     chk("b_dec", 32'(bus.b), 32'h100400);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0; bus.wait_i = 1'b0; bus.ir_op = 2'b00; bus.ac_sign = 1'b0;
    #1;
    chk_st("rst_state", INIT);
    chk("rst_b", 32'(bus.b), 32'h000040);
    chk("rst_done", 32'(bus.instr_done), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);

    // LOAD, no wait states: instr_done lands in cycle 12
    @(negedge clk);
    bus.run = 1'b1; rst_n = 1'b1;
    to_dec();
    tick(); chk_st("ld_rreq1", R_REQ);
    tick(); chk_st("ld_rreq2", R_REQ);
    tick(); chk_st("ld_rlat", R_LAT);
    tick(); chk_st("ld0", LD0); chk("b_ld0", 32'(bus.b), 32'h014080);
    chk("ld0_done", 32'(bus.instr_done), 32'h0);
    tick(); chk_st("ld1", LD1); chk("b_ld1", 32'(bus.b), 32'h044001);
    chk("ld1_done", 32'(bus.instr_done), 32'h1);

    // ADD with 5 busy cycles in R_REQ -> 6 cycles held
    bus.ir_op = OP_ADD;
    to_dec();
    bus.wait_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(); chk_st($sformatf("ad_rreq%0d", i), R_REQ);
    end
    bus.wait_i = 1'b0;
    tick(); chk_st("ad_rlat", R_LAT);
    tick(); chk_st("ad0", AD0); chk("b_ad0", 32'(bus.b), 32'h030080);
    tick(); chk_st("ad1", AD1); chk("b_ad1", 32'(bus.b), 32'h048001);
    chk("ad1_done", 32'(bus.instr_done), 32'h1);

    // STORE: done only on the accepting ST_REQ cycle
    bus.ir_op = OP_STORE;
    to_dec();
    tick(); chk_st("st0", ST0); chk("b_st0", 32'(bus.b), 32'h000102);
    tick(); chk_st("streq1", ST_REQ); chk("b_streq", 32'(bus.b), 32'h00300C);
    chk("streq1_done", 32'(bus.instr_done), 32'h0);
    tick(); chk_st("streq2", ST_REQ);
    chk("streq2_done", 32'(bus.instr_done), 32'h1);

    // BRN: taken and not-taken control words in the single BR cycle
    bus.ir_op = OP_BRN; bus.ac_sign = 1'b1;
    to_dec();
    tick(); chk_st("br", BR); chk("b_br_taken", 32'(bus.b), 32'h100010);
    chk("br_done", 32'(bus.instr_done), 32'h1);
    bus.ac_sign = 1'b0;
    #1;
    chk("b_br_not", 32'(bus.b), 32'h0);

    // ADD with run dropped in DEC completes, then parks in IDLE
    bus.ir_op = OP_ADD;
    to_dec();
    bus.run = 1'b0;
    tick(); tick(); tick(); tick(); chk_st("stop_ad0", AD0);
    tick(); chk_st("stop_ad1", AD1); chk("stop_done", 32'(bus.instr_done), 32'h1);
    tick(); chk_st("stop_idle", IDLE); chk("b_idle", 32'(bus.b), 32'h0);
    tick(); chk_st("stop_idle2", IDLE);

    // Async reset while in R_REQ
    bus.run = 1'b1; bus.ir_op = OP_LOAD;
    to_dec();
    tick(); chk_st("ar_rreq", R_REQ);
    #2 rst_n = 1'b0;
    #1;
    chk_st("ar_state", INIT);
    chk("ar_b", 32'(bus.b), 32'h000040);
    chk("ar_done", 32'(bus.instr_done), 32'h0);

    // wait_i stuck high in F_REQ
    @(negedge clk);
    rst_n = 1'b1; bus.wait_i = 1'b1;
    tick(); chk_st("to_fmar", F_MAR);
    for (int i = 1; i <= 8; i++) begin
      tick(); chk_st($sformatf("to_freq%0d", i), F_REQ);
      chk($sformatf("to_fault%0d", i), 32'(bus.fault), 32'h0);
    end
    tick();
`ifdef SAM_SEQ_TIMEOUT_EN
    chk_st("to_state", FAULT);
    chk("to_fault", 32'(bus.fault), 32'h1);
    chk("to_b", 32'(bus.b), 32'h0);
    chk("to_done", 32'(bus.instr_done), 32'h0);
    bus.wait_i = 1'b0;
    tick(); tick(); tick();
    chk_st("to_sticky", FAULT);
    chk("to_sticky_fault", 32'(bus.fault), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("to_rst_fault", 32'(bus.fault), 32'h0);
    chk_st("to_rst_state", INIT);
`else
    chk_st("noto_state", F_REQ);
    chk("noto_fault", 32'(bus.fault), 32'h0);
    bus.wait_i = 1'b0;
    tick(); chk_st("noto_flat", F_LAT);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
